// File: rtl/mux_rr_nx1_if.sv
// mux_rr_nx1_if: handshake/bus bundle for the N-to-1 registered mux.
//   mode      - 0 manual select, 1 round-robin scan
//   sel       - channel index used in manual mode
//   in_data   - packed channel data, channel k at [k*W +: W]
//   in_valid  - per-channel valid
//   in_ready  - per-channel accept (driven by the mux)
//   out_data  - registered selected word
//   out_chan  - channel that supplied out_data
//   out_valid - output register holds a word
//   out_ready - consumer accepts out_data
// slave modport is the mux side; master modport is the producer/consumer side.
interface mux_rr_nx1_if #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
);
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_chan;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-channel, W-bit registered multiplexer with valid/ready on
// every input and on the output. Manual mode picks channel `sel`; scan mode
// uses a round-robin pointer to pick the first valid channel at or after ptr.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mux_rr_nx1_if.slave (mode, sel, in_*, out_*)
// The output register is a one-entry buffer; it reloads whenever it is empty
// or being drained, so a word can be replaced on the same edge it is consumed.
module mux_rr_nx1 #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_rr_nx1_if.slave  bus
);
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_chan_q, out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load_en;
    logic            grant;
    logic [SELW-1:0] g;
    logic [W-1:0]    data_sel;
    logic [N-1:0]    in_ready_c;

    always_comb begin
        // rst_n folded in so in_ready is low throughout reset.
        load_en = rst_n & (~out_valid_q | bus.out_ready);

        grant = 1'b0;
        g     = '0;
        if (!bus.mode) begin
            // Manual: an out-of-range sel matches no channel, so no grant.
            for (int k = 0; k < N; k++) begin
                if (bus.sel == SELW'(k) && bus.in_valid[k]) begin
                    grant = 1'b1;
                    g     = SELW'(k);
                end
            end
        end else begin
            // Scan: descending loops make the lowest index win. The second
            // pass (k >= ptr) overrides the first (wrapped, k < ptr), giving
            // the search order ptr..N-1, 0..ptr-1.
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.in_valid[k] && SELW'(k) < ptr_q) begin
                    grant = 1'b1;
                    g     = SELW'(k);
                end
            end
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.in_valid[k] && SELW'(k) >= ptr_q) begin
                    grant = 1'b1;
                    g     = SELW'(k);
                end
            end
        end

        data_sel   = '0;
        in_ready_c = '0;
        for (int k = 0; k < N; k++) begin
            if (g == SELW'(k)) begin
                data_sel      = bus.in_data[k*W +: W];
                in_ready_c[k] = load_en & grant;
            end
        end

        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            // No grant while loadable drains the buffer; data/chan hold.
            out_valid_d = grant;
            if (grant) begin
                out_data_d = data_sel;
                out_chan_d = g;
                if (bus.mode) begin
                    ptr_d = (g == SELW'(N - 1)) ? '0 : g + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule
